btn_onehot_capture: RTL
=======================

Name: btn_onehot_capture

Overview:
- Front-end stage for the 4-to-2 binary encoder: turns three raw push-button inputs into a clean, held one-hot request on onehot[3:1], which drives the encoder's A[3:1] directly.
- Synchronises, debounces and edge-detects each button, then resolves simultaneous presses by priority.
- Holds exactly one bit set until the consumer acknowledges, so the encoder never sees a multi-hot or glitching input.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronised samples required to accept a level change (legal range 2..2^CNT_W-1)
CNT_W, 3, width of each per-button debounce counter

Ports:
clk  input  1  system clock, all flops rising-edge
rst  input  1  synchronous, active-high reset
btn_raw  input  [3:1]  asynchronous raw button levels, 1 = pressed
ack  input  1  consumer has taken the current request
onehot  output  [3:1]  held one-hot request to the encoder, all-zero when idle
valid  output  1  onehot holds a request
overrun  output  1  sticky: a press event was dropped

Behaviour:
- Interface: one clock domain (clk); rst synchronous, active-high, sampled on rising clk.
- Reset values: onehot=3'b000, valid=0, overrun=0, FSM=IDLE. Sync flops, debounced levels deb[3:1], delayed levels deb_d[3:1] and all counters clear to 0.
- Synchroniser: two flops per bit, giving btn_s[3:1]. There is no combinational path from btn_raw to any output.
- Debounce, per bit i, each clock:
  - If btn_s[i]==deb[i]: cnt[i]<=0.
  - Else if cnt[i]==DEB_CYCLES-1: deb[i]<=btn_s[i], cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
  - Net effect: deb changes only after DEB_CYCLES consecutive differing samples. A pulse shorter than DEB_CYCLES synchronised cycles is ignored, and the counter restarts on any bounce.
- Edge detect: deb_d<=deb each clock. press[i] = deb[i] & ~deb_d[i] is a one-cycle pulse. Releases generate no event.
- Priority: if several press bits are high in the same cycle, the highest index wins (3 > 2 > 1). Losing bits set overrun.
- FSM:
  - IDLE: valid=0, onehot=0. On any press, latch onehot to the winning bit, valid<=1, go to HOLD.
  - HOLD: onehot and valid are held stable. Any press pulse is dropped and sets overrun.
  - HOLD with ack=1: onehot<=0, valid<=0, go to IDLE. A press arriving in the same cycle as ack is dropped and sets overrun. A new request can be accepted from the next cycle.
  - ack in IDLE is ignored.
- Invariant: onehot is always 000 or exactly one bit set. valid == |onehot.
- Latency: edge k is the first clk edge at which the sync stage-1 flop samples btn_raw[i]=1 and stays 1. Then:
  - deb[i] rises at edge k+1+DEB_CYCLES.
  - onehot/valid update at edge k+2+DEB_CYCLES, which is edge k+6 for the default.
- overrun stays at 1 until rst. Neither ack nor new requests clear it.
- Held button: produces one request only. A re-press requires deb to fall (DEB_CYCLES low samples) and then rise again.
- Reset mid-operation: everything clears within the reset cycle. A button held through reset release is seen as a fresh press after the full latency.

Test Plan:
- Reset: rst=1 for 2 cycles with btn_raw=3'b111 -> onehot=000, valid=0, overrun=0 throughout. After release, onehot=100, valid=1 at edge DEB_CYCLES+2 after the first sampling edge.
- Single press: btn_raw=3'b001 held, DEB_CYCLES=4 -> onehot=001, valid=1 exactly 6 edges after the first sampling edge. Both stay stable with no ack for 20 cycles. ack=1 for 1 cycle -> onehot=000, valid=0 next edge.
- Bounce: btn_raw[2] toggled 1,0,1,1,0 over successive cycles, then held 1 -> no request during the bounce. onehot=010 only after 4 consecutive stable synchronised samples.
- Glitch: btn_raw[3] high for 3 cycles then low (DEB_CYCLES=4) -> onehot stays 000, overrun=0.
- Simultaneous press: btn_raw 000->011 on the same edge -> onehot=010, overrun=1 (bit 1 dropped). After ack and release, overrun is still 1.
- Press during HOLD: request 001 outstanding, press button 3 -> onehot stays 001, overrun=1. After ack, with button 3 still held -> no new request until it is released and pressed again.

Source files
------------

// File: rtl/btn_onehot_capture.sv
// Push-button front end for the 4-to-2 encoder: sync, debounce, press detect,
// priority resolve, and hold a one-hot request until the consumer acks.
//
//   state | meaning
//   IDLE  | no request outstanding, onehot = 000, next press is accepted
//   HOLD  | one request latched on onehot, waiting for ack; presses are dropped
module btn_onehot_capture #(
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:1] btn_raw,
   input  logic       ack,
   output logic [3:1] onehot,
   output logic       valid,
   output logic       overrun
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   state_t           state, state_n;
   logic [3:1]       sync1, btn_s, deb, deb_d, press, win;
   logic             multi;
   logic [3:1]       onehot_n;
   logic             overrun_n;
   logic [CNT_W-1:0] cnt [3:1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         btn_s <= '0;
         deb   <= '0;
         deb_d <= '0;
         for (int i = 1; i <= 3; i++) cnt[i] <= '0;
      end else begin
         sync1 <= btn_raw;
         btn_s <= sync1;
         deb_d <= deb;
         // any sample agreeing with deb restarts the count, so bounces never accumulate
         for (int i = 1; i <= 3; i++) begin
            if (btn_s[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= btn_s[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign press = deb & ~deb_d;
   assign multi = (press[3] & (press[2] | press[1])) | (press[2] & press[1]);

   always_comb begin
      win = 3'b000;
      if (press[3])      win = 3'b100;
      else if (press[2]) win = 3'b010;
      else if (press[1]) win = 3'b001;
   end

   always_comb begin
      state_n   = state;
      onehot_n  = onehot;
      overrun_n = overrun;
      case (state)
         IDLE: begin
            if (|press) begin
               onehot_n = win;
               state_n  = HOLD;
               if (multi) overrun_n = 1'b1;
            end
         end
         HOLD: begin
            if (|press) overrun_n = 1'b1;
            if (ack) begin
               onehot_n = 3'b000;
               state_n  = IDLE;
            end
         end
         default: begin
            onehot_n = 3'b000;
            state_n  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         onehot  <= 3'b000;
         overrun <= 1'b0;
      end else begin
         state   <= state_n;
         onehot  <= onehot_n;
         overrun <= overrun_n;
      end
   end

   assign valid = (state == HOLD);

endmodule
